// File: rtl/da_wave_pkg.sv
// Shared types and constants for the DA waveform sequencer.
// Imported by the interface, the accumulator and the top.
package da_wave_pkg;

  localparam int DW_DEF      = 10;
  localparam int FRAC_DEF    = 6;
  localparam int SEG_NUM_DEF = 8;
  localparam int CH_NUM      = 16;

  localparam logic [3:0] ADDR_IDLE  = 4'd8;
  localparam logic [3:0] ADDR_START = 4'd9;

  localparam int SLOPE_LSB = 0;
  localparam int SLOPE_MSB = 15;
  localparam int LEN_LSB   = 16;
  localparam int LEN_MSB   = 27;
  localparam int SLOPE_W   = SLOPE_MSB - SLOPE_LSB + 1;
  localparam int LEN_W     = LEN_MSB - LEN_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_FINISH
  } wave_state_e;

endpackage

// File: rtl/da_wave_if.sv
// Host config, fire control and DA driver handshake bundle.
// The slave side is the waveform sequencer.
interface da_wave_if;

  logic        CfgWr;
  logic [3:0]  CfgAddr;
  logic [31:0] CfgData;
  logic        Fire;
  logic [15:0] ChEn;
  logic        RdAck;
  logic        Busy;
  logic        Done;
  logic        FireErr;

  logic [da_wave_pkg::DW_DEF-1:0] DA0Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA1Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA2Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA3Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA4Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA5Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA6Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA7Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA8Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA9Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA10Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA11Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA12Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA13Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA14Data;
  logic [da_wave_pkg::DW_DEF-1:0] DA15Data;

  modport master (
    output CfgWr, CfgAddr, CfgData,
    output Fire, ChEn, RdAck,
    input  Busy, Done, FireErr,
    input  DA0Data, DA1Data, DA2Data, DA3Data,
    input  DA4Data, DA5Data, DA6Data, DA7Data,
    input  DA8Data, DA9Data, DA10Data, DA11Data,
    input  DA12Data, DA13Data, DA14Data, DA15Data
  );

  modport slave (
    input  CfgWr, CfgAddr, CfgData,
    input  Fire, ChEn, RdAck,
    output Busy, Done, FireErr,
    output DA0Data, DA1Data, DA2Data, DA3Data,
    output DA4Data, DA5Data, DA6Data, DA7Data,
    output DA8Data, DA9Data, DA10Data, DA11Data,
    output DA12Data, DA13Data, DA14Data, DA15Data
  );

endinterface

// File: rtl/da_wave_sat_acc.sv
// Saturating add of a signed slope into an unsigned level accumulator.
// Purely combinational; clamps to [0, all-ones] instead of wrapping.
module da_wave_sat_acc
  import da_wave_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic [DW+FRAC-1:0]        acc_i,
  input  logic signed [SLOPE_W-1:0] slope_i,
  output logic [DW+FRAC-1:0]        acc_o
);

  localparam int AW = DW + FRAC;
  localparam int SW = AW + 2;

  logic signed [SW-1:0] sum;

  always_comb begin
    sum = $signed({2'b00, acc_i})
        + $signed({{(SW-SLOPE_W){slope_i[SLOPE_W-1]}}, slope_i});
    if (sum[SW-1]) begin
      acc_o = '0;
    end else if (sum[AW]) begin
      acc_o = '1;
    end else begin
      acc_o = sum[AW-1:0];
    end
  end

endmodule

// File: rtl/da_wave_gen.sv
// Piecewise-linear waveform sequencer feeding the 16-channel DA driver.
// Steps one sample per RdAck; disabled or idle channels hold IdleLevel.
module da_wave_gen
  import da_wave_pkg::*;
#(
  parameter int SEG_NUM = SEG_NUM_DEF,
  parameter int DW      = DW_DEF,
  parameter int FRAC    = FRAC_DEF
) (
  input logic     Clk1,
  input logic     Rst,
  da_wave_if.slave bus
);

  localparam int AW = DW + FRAC;
  localparam int IW = $clog2(SEG_NUM);

  wave_state_e state_q, state_d;

  logic [AW-1:0]      acc_q, acc_d, acc_sum;
  logic [IW-1:0]      seg_q, seg_d, seg_inc;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [DW-1:0]      idle_q, idle_d;
  logic [DW-1:0]      start_q, start_d;
  logic [CH_NUM-1:0]  chen_q, chen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;
  logic               last_seg;

  logic signed [SLOPE_W-1:0] slope_q [SEG_NUM];
  logic signed [SLOPE_W-1:0] slope_d [SEG_NUM];
  logic [LEN_W-1:0]          len_q   [SEG_NUM];
  logic [LEN_W-1:0]          len_d   [SEG_NUM];
  logic [DW-1:0]             da_q    [CH_NUM];
  logic [DW-1:0]             da_d    [CH_NUM];

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^bus.CfgData[31:LEN_MSB+1];

  da_wave_sat_acc #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_sat_acc (
    .acc_i   (acc_q),
    .slope_i (slope_q[seg_q]),
    .acc_o   (acc_sum)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    seg_d    = seg_q;
    rem_d    = rem_q;
    idle_d   = idle_q;
    start_d  = start_q;
    chen_d   = chen_q;
    slope_d  = slope_q;
    len_d    = len_q;
    done_d   = 1'b0;
    seg_inc  = seg_q + IW'(1);
    last_seg = (seg_q == IW'(SEG_NUM-1))
            || (len_q[seg_inc] == '0);
    ferr_d   = bus.Fire && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Fire) begin
          if (len_q[0] != '0) begin
            state_d = ST_ARM;
            chen_d  = bus.ChEn;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.CfgWr) begin
          if (int'(bus.CfgAddr) < SEG_NUM) begin
            slope_d[bus.CfgAddr[IW-1:0]] =
              bus.CfgData[SLOPE_MSB:SLOPE_LSB];
            len_d[bus.CfgAddr[IW-1:0]] =
              bus.CfgData[LEN_MSB:LEN_LSB];
          end else if (bus.CfgAddr == ADDR_IDLE) begin
            idle_d = bus.CfgData[DW-1:0];
          end else if (bus.CfgAddr == ADDR_START) begin
            start_d = bus.CfgData[DW-1:0];
          end
        end
      end
      ST_ARM: begin
        if (bus.RdAck) begin
          acc_d   = {start_q, {FRAC{1'b0}}};
          seg_d   = '0;
          rem_d   = len_q[0];
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.RdAck) begin
          acc_d = acc_sum;
          if (rem_q == LEN_W'(1)) begin
            if (last_seg) begin
              state_d = ST_FINISH;
            end else begin
              seg_d = seg_inc;
              rem_d = len_q[seg_inc];
            end
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      ST_FINISH: begin
        if (bus.RdAck) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    // Outputs trail the state/acc registers by one cycle.
    for (int ch = 0; ch < CH_NUM; ch++) begin
      if (((state_q == ST_RUN) || (state_q == ST_FINISH))
          && chen_q[ch]) begin
        da_d[ch] = acc_q[AW-1:FRAC];
      end else begin
        da_d[ch] = idle_q;
      end
    end
  end

  always_ff @(posedge Clk1) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      seg_q   <= '0;
      rem_q   <= '0;
      idle_q  <= '0;
      start_q <= '0;
      chen_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      for (int i = 0; i < SEG_NUM; i++) begin
        slope_q[i] <= '0;
        len_q[i]   <= '0;
      end
      for (int ch = 0; ch < CH_NUM; ch++) begin
        da_q[ch] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      seg_q   <= seg_d;
      rem_q   <= rem_d;
      idle_q  <= idle_d;
      start_q <= start_d;
      chen_q  <= chen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      slope_q <= slope_d;
      len_q   <= len_d;
      da_q    <= da_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.FireErr  = ferr_q;
  assign bus.DA0Data  = da_q[0];
  assign bus.DA1Data  = da_q[1];
  assign bus.DA2Data  = da_q[2];
  assign bus.DA3Data  = da_q[3];
  assign bus.DA4Data  = da_q[4];
  assign bus.DA5Data  = da_q[5];
  assign bus.DA6Data  = da_q[6];
  assign bus.DA7Data  = da_q[7];
  assign bus.DA8Data  = da_q[8];
  assign bus.DA9Data  = da_q[9];
  assign bus.DA10Data = da_q[10];
  assign bus.DA11Data = da_q[11];
  assign bus.DA12Data = da_q[12];
  assign bus.DA13Data = da_q[13];
  assign bus.DA14Data = da_q[14];
  assign bus.DA15Data = da_q[15];

endmodule

// File: tb/tb_da_wave_gen.sv
// Scoreboard bench for da_wave_gen: a level-list model queues the
// channel vector expected at every RdAck; a monitor pops and compares.
module tb_da_wave_gen;
  import da_wave_pkg::*;

  typedef struct packed {
    logic [15:0][9:0] da;
    logic             busy;
  } exp_t;

  logic Clk1 = 1'b0;
  logic Rst;

  always #5 Clk1 = ~Clk1;

  da_wave_if bus ();

  da_wave_gen #(
    .SEG_NUM (8),
    .DW      (10),
    .FRAC    (6)
  ) dut (
    .Clk1 (Clk1),
    .Rst  (Rst),
    .bus  (bus)
  );

  logic [15:0][9:0] da_v;
  assign da_v = {bus.DA15Data, bus.DA14Data, bus.DA13Data,
                 bus.DA12Data, bus.DA11Data, bus.DA10Data,
                 bus.DA9Data,  bus.DA8Data,  bus.DA7Data,
                 bus.DA6Data,  bus.DA5Data,  bus.DA4Data,
                 bus.DA3Data,  bus.DA2Data,  bus.DA1Data,
                 bus.DA0Data};

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   ferr_cnt = 0;

  int m_slope [8];
  int m_len   [8];
  int m_idle;
  int m_start;

  task automatic chk(input string nm,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int lvl, input bit busy,
                              input logic [15:0] en,
                              input int idle);
    exp_t e;
    for (int ch = 0; ch < 16; ch++) begin
      e.da[ch] = en[ch] ? lvl[9:0] : idle[9:0];
    end
    e.busy = busy;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clk1);
      if (!Rst) begin
        if (bus.Done)    done_cnt++;
        if (bus.FireErr) ferr_cnt++;
        if (bus.RdAck) begin
          n_vec++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL rdack_unexpected: no queued sample");
          end else begin
            e = q.pop_front();
            if (da_v !== e.da || bus.Busy !== e.busy) begin
              n_err++;
              $display("FAIL sample: got da=%h busy=%b want da=%h busy=%b",
                       da_v, bus.Busy, e.da, e.busy);
            end
          end
        end
      end
    end
  endtask

  task automatic cfg(input int addr, input logic [31:0] data);
    bus.CfgAddr = addr[3:0];
    bus.CfgData = data;
    bus.CfgWr   = 1'b1;
    @(posedge Clk1); #1;
    bus.CfgWr   = 1'b0;
  endtask

  task automatic program_all();
    logic [31:0] w;
    for (int s = 0; s < 8; s++) begin
      w = {4'h0, m_len[s][11:0], m_slope[s][15:0]};
      cfg(s, w);
    end
    cfg(8, 32'(m_idle));
    cfg(9, 32'(m_start));
  endtask

  task automatic rdack();
    repeat (7) @(posedge Clk1);
    #1 bus.RdAck = 1'b1;
    @(posedge Clk1); #1;
    bus.RdAck = 1'b0;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 8; s++) begin
      m_slope[s] = 0;
      m_len[s]   = 0;
    end
    m_idle  = 0;
    m_start = 0;
  endtask

  // abort_at >= 0 pulses Rst instead of issuing that RdAck.
  task automatic play(input logic [15:0] chen, input bit inject,
                      input int abort_at);
    int lv[$];
    int acc;
    int n_rd;
    int d0;
    int f0;
    acc = m_start * 64;
    lv.push_back(m_start);
    for (int s = 0; s < 8; s++) begin
      if (m_len[s] == 0) break;
      for (int k = 0; k < m_len[s]; k++) begin
        acc = acc + m_slope[s];
        if (acc < 0)     acc = 0;
        if (acc > 65535) acc = 65535;
        lv.push_back(acc / 64);
      end
    end
    d0 = done_cnt;
    f0 = ferr_cnt;
    bus.ChEn = chen;
    bus.Fire = 1'b1;
    @(posedge Clk1); #1;
    bus.Fire = 1'b0;
    if (m_len[0] == 0) begin
      chk("nofire_done", bus.Done, 1);
      chk("nofire_busy", bus.Busy, 0);
      q.push_back(mk(0, 1'b0, 16'h0, m_idle));
      q.push_back(mk(0, 1'b0, 16'h0, m_idle));
      rdack();
      rdack();
      chk("nofire_done_cnt", done_cnt - d0, 1);
      return;
    end
    chk("fire_busy", bus.Busy, 1);
    chk("fire_no_done", bus.Done, 0);
    q.push_back(mk(0, 1'b1, 16'h0, m_idle));
    foreach (lv[i]) q.push_back(mk(lv[i], 1'b1, chen, m_idle));
    q.push_back(mk(0, 1'b0, 16'h0, m_idle));
    n_rd = lv.size() + 2;
    for (int i = 0; i < n_rd; i++) begin
      if (i == abort_at) begin
        q.delete();
        Rst = 1'b1;
        @(posedge Clk1); #1;
        Rst = 1'b0;
        chk("rst_da", da_v, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        clear_model();
        return;
      end
      rdack();
      if (i == n_rd - 2) begin
        chk("done_pulse", bus.Done, 1);
        chk("busy_fall", bus.Busy, 0);
      end
      if (inject && i == 2) begin
        bus.Fire    = 1'b1;
        bus.CfgWr   = 1'b1;
        bus.CfgAddr = 4'd0;
        bus.CfgData = $urandom;
        @(posedge Clk1); #1;
        bus.Fire  = 1'b0;
        bus.CfgWr = 1'b0;
        chk("fireerr_pulse", bus.FireErr, 1);
        chk("busy_hold", bus.Busy, 1);
      end
    end
    chk("done_once", done_cnt - d0, 1);
    chk("fireerr_cnt", ferr_cnt - f0, inject ? 1 : 0);
  endtask

  initial begin
    int nseg;
    Rst         = 1'b1;
    bus.CfgWr   = 1'b0;
    bus.CfgAddr = '0;
    bus.CfgData = '0;
    bus.Fire    = 1'b0;
    bus.ChEn    = '0;
    bus.RdAck   = 1'b0;
    clear_model();
    fork
      monitor();
    join_none
    repeat (3) @(posedge Clk1);
    #1 Rst = 1'b0;
    chk("reset_da", da_v, 0);
    chk("reset_busy", bus.Busy, 0);
    chk("reset_done", bus.Done, 0);
    chk("reset_fireerr", bus.FireErr, 0);

    // Half-LSB ramp on channel 0 only.
    m_idle = 50; m_start = 200;
    m_slope[0] = 32; m_len[0] = 4;
    program_all();
    play(16'h0001, 1'b0, -1);

    // Rejected Fire and ignored CfgWr mid-run, then replay unchanged.
    play(16'h0001, 1'b1, -1);
    play(16'h0001, 1'b0, -1);

    // Saturation at the top and at zero.
    clear_model();
    m_idle = 3; m_start = 1020;
    m_slope[0] = 256; m_len[0] = 3;
    program_all();
    play(16'h8421, 1'b0, -1);
    m_start = 5; m_slope[0] = -640; m_len[0] = 2;
    program_all();
    play(16'hffff, 1'b0, -1);

    // Empty table: immediate Done.
    clear_model();
    m_idle = 77;
    program_all();
    play(16'hffff, 1'b0, -1);

    // Full table with no terminator.
    clear_model();
    m_idle = 900;
    for (int s = 0; s < 8; s++) begin
      m_slope[s] = 64;
      m_len[s]   = 1;
    end
    program_all();
    play(16'h00ff, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      m_idle  = $urandom_range(0, 1023);
      m_start = $urandom_range(0, 1023);
      nseg    = $urandom_range(1, 8);
      for (int s = 0; s < 8; s++) begin
        if ($urandom_range(0, 3) == 0)
          m_slope[s] = int'($urandom_range(0, 65535)) - 32768;
        else
          m_slope[s] = int'($urandom_range(0, 8191)) - 4096;
        m_len[s] = (s == nseg) ? 0 : $urandom_range(1, 5);
      end
      program_all();
      play(16'($urandom), r[0], -1);
    end

    // Reset mid-run clears the table, so the next Fire ends at once.
    clear_model();
    m_idle = 50; m_start = 200;
    m_slope[0] = 32; m_len[0] = 4;
    program_all();
    play(16'hffff, 1'b0, 3);
    play(16'hffff, 1'b0, -1);

    repeat (4) @(posedge Clk1);
    #1 chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
